// File: rtl/ysyx_23060124_wbu_pkg.sv
// Shared widths, load-size encodings, FSM states and response codes for the writeback unit.
// The optional same-cycle forwarding port is enabled with YSYX_23060124_WB_BYPASS_EN.
package ysyx_23060124_wbu_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int RADDR_DEF = 4;

    typedef enum logic [1:0] {
        LD_B   = 2'b00,
        LD_H   = 2'b01,
        LD_W   = 2'b10,
        LD_RSV = 2'b11
    } ld_size_e;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_WAIT_MEM = 2'b01,
        S_WRITE    = 2'b10
    } wb_state_e;

    localparam logic [1:0] RRESP_OK = 2'b00;

    // Natural alignment check; the reserved size is always treated as illegal.
    function automatic logic ld_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            LD_B:    bad = 1'b0;
            LD_H:    bad = addr_lo[0];
            LD_W:    bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ysyx_23060124_wbu_load_align.sv
// Combinational load formatter: selects the byte/half lane of an aligned memory word
// and sign- or zero-extends it to XLEN; flags misaligned or reserved-size accesses.
module ysyx_23060124_load_align
    import ysyx_23060124_wbu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [1:0]      size,
    input  logic            ld_unsigned,
    output logic [XLEN-1:0] data,
    output logic            misaligned
);

    function automatic logic [XLEN-1:0] ext8(input logic signed [7:0] v, input logic zext);
        return {{(XLEN-8){v[7] & ~zext}}, v};
    endfunction

    function automatic logic [XLEN-1:0] ext16(input logic signed [15:0] v, input logic zext);
        return {{(XLEN-16){v[15] & ~zext}}, v};
    endfunction

    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;

    assign lane_b = rdata[{addr_lo, 3'b000} +: 8];
    assign lane_h = rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        data       = rdata;
        misaligned = ld_misaligned(size, addr_lo);
        case (size)
            LD_B:    data = ext8(lane_b, ld_unsigned);
            LD_H:    data = ext16(lane_h, ld_unsigned);
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/ysyx_23060124_wbu.sv
// Writeback unit: retires one instruction per handshake, waits for and formats load data,
// and drives the register-file write port. Define YSYX_23060124_WB_BYPASS_EN for forwarding outputs.
module ysyx_23060124_wbu
    import ysyx_23060124_wbu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int RADDR = RADDR_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RADDR-1:0] in_rd,
    input  logic             in_rd_wen,
    input  logic             in_is_load,
    input  logic [1:0]       in_ld_size,
    input  logic             in_ld_unsigned,
    input  logic [1:0]       in_addr_lo,
    input  logic [XLEN-1:0]  in_result,
    input  logic             mem_rvalid,
    output logic             mem_rready,
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic [1:0]       mem_rresp,
    output logic             o_wen,
    output logic [RADDR-1:0] o_waddr,
    output logic [XLEN-1:0]  o_wdata,
    output logic             o_commit,
    output logic             o_fault
`ifdef YSYX_23060124_WB_BYPASS_EN
    ,
    output logic             o_fwd_valid,
    output logic [RADDR-1:0] o_fwd_addr,
    output logic [XLEN-1:0]  o_fwd_data
`endif
);

    wb_state_e state, state_nxt;

    logic             accept;
    logic             rsp_take;
    logic [RADDR-1:0] rd_p0;
    logic             rd_wen_p0;
    logic [1:0]       ld_size_p0;
    logic             ld_unsigned_p0;
    logic [1:0]       addr_lo_p0;
    logic [XLEN-1:0]  ld_data;
    logic             ld_misalign;
    logic             ld_fault;

    assign in_ready   = (state == S_IDLE) || (state == S_WRITE);
    assign mem_rready = (state == S_WAIT_MEM);
    assign accept     = in_valid & in_ready;
    assign rsp_take   = mem_rvalid & mem_rready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_WRITE: begin
                if (accept) begin
                    state_nxt = in_is_load ? S_WAIT_MEM : S_WRITE;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT_MEM: begin
                if (rsp_take) begin
                    state_nxt = S_WRITE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stage p0: hold the accepted load's fields while memory responds.
    always_ff @(posedge clk) begin
        if (accept && in_is_load) begin
            rd_p0          <= in_rd;
            rd_wen_p0      <= in_rd_wen;
            ld_size_p0     <= in_ld_size;
            ld_unsigned_p0 <= in_ld_unsigned;
            addr_lo_p0     <= in_addr_lo;
        end
    end

    ysyx_23060124_load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .rdata       (mem_rdata),
        .addr_lo     (addr_lo_p0),
        .size        (ld_size_p0),
        .ld_unsigned (ld_unsigned_p0),
        .data        (ld_data),
        .misaligned  (ld_misalign)
    );

    assign ld_fault = (mem_rresp != RRESP_OK) | ld_misalign;

    // Stage p1: write-port registers, valid exactly in the WRITE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_wen    <= 1'b0;
            o_waddr  <= '0;
            o_wdata  <= '0;
            o_commit <= 1'b0;
            o_fault  <= 1'b0;
        end else begin
            o_wen    <= 1'b0;
            o_commit <= 1'b0;
            o_fault  <= 1'b0;
            if (rsp_take) begin
                o_wen    <= rd_wen_p0 & (|rd_p0) & ~ld_fault;
                o_waddr  <= rd_p0;
                o_wdata  <= ld_data;
                o_commit <= 1'b1;
                o_fault  <= ld_fault;
            end else if (accept && !in_is_load) begin
                o_wen    <= in_rd_wen & (|in_rd);
                o_waddr  <= in_rd;
                o_wdata  <= in_result;
                o_commit <= 1'b1;
            end
        end
    end

`ifdef YSYX_23060124_WB_BYPASS_EN
    // Address/data are gated so the forward port reads zero outside WRITE.
    assign o_fwd_valid = o_wen;
    assign o_fwd_addr  = (state == S_WRITE) ? o_waddr : '0;
    assign o_fwd_data  = (state == S_WRITE) ? o_wdata : '0;
`endif

endmodule

// File: tb/tb_ysyx_23060124_wbu.sv
// Directed bench for the writeback unit: ALU writes, formatted loads, faults and reset mid-load.
module tb_ysyx_23060124_wbu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_rd;
    logic        in_rd_wen;
    logic        in_is_load;
    logic [1:0]  in_ld_size;
    logic        in_ld_unsigned;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_result;
    logic        mem_rvalid;
    logic        mem_rready;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        o_wen;
    logic [3:0]  o_waddr;
    logic [31:0] o_wdata;
    logic        o_commit;
    logic        o_fault;
`ifdef YSYX_23060124_WB_BYPASS_EN
    logic        o_fwd_valid;
    logic [3:0]  o_fwd_addr;
    logic [31:0] o_fwd_data;
`endif

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    ysyx_23060124_wbu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rd          (in_rd),
        .in_rd_wen      (in_rd_wen),
        .in_is_load     (in_is_load),
        .in_ld_size     (in_ld_size),
        .in_ld_unsigned (in_ld_unsigned),
        .in_addr_lo     (in_addr_lo),
        .in_result      (in_result),
        .mem_rvalid     (mem_rvalid),
        .mem_rready     (mem_rready),
        .mem_rdata      (mem_rdata),
        .mem_rresp      (mem_rresp),
        .o_wen          (o_wen),
        .o_waddr        (o_waddr),
        .o_wdata        (o_wdata),
        .o_commit       (o_commit),
        .o_fault        (o_fault)
`ifdef YSYX_23060124_WB_BYPASS_EN
        ,
        .o_fwd_valid    (o_fwd_valid),
        .o_fwd_addr     (o_fwd_addr),
        .o_fwd_data     (o_fwd_data)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_write(input string tag, input logic wen, input logic [3:0] waddr,
                               input logic [31:0] wdata, input logic fault);
        check({tag, ".commit"}, 32'(o_commit), 32'd1);
        check({tag, ".wen"},    32'(o_wen),    32'(wen));
        check({tag, ".fault"},  32'(o_fault),  32'(fault));
        if (wen) begin
            check({tag, ".waddr"}, 32'(o_waddr), 32'(waddr));
            check({tag, ".wdata"}, o_wdata, wdata);
        end
    endtask

    // Presents a load for acceptance on the next edge.
    task automatic issue_load(input logic [3:0] rd, input logic [1:0] size,
                              input logic uns, input logic [1:0] lo);
        in_valid = 1'b1; in_is_load = 1'b1; in_rd = rd; in_rd_wen = 1'b1;
        in_ld_size = size; in_ld_unsigned = uns; in_addr_lo = lo; in_result = 32'h0;
    endtask

    // Accepts the pending load, idles `waits` cycles in WAIT_MEM, then returns the response.
    task automatic finish_load(input string tag, input logic [31:0] rdata,
                               input logic [1:0] rresp, input int waits);
        tick();
        in_valid = 1'b0; in_is_load = 1'b0; mem_rvalid = 1'b0;
        check({tag, ".wait_ready"},  32'(in_ready),   32'd0);
        check({tag, ".wait_rready"}, 32'(mem_rready), 32'd1);
        check({tag, ".wait_commit"}, 32'(o_commit),   32'd0);
        for (int i = 0; i < waits; i++) begin
            tick();
            check({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
        end
        mem_rvalid = 1'b1; mem_rdata = rdata; mem_rresp = rresp;
        tick();
        mem_rvalid = 1'b0; mem_rresp = 2'b00;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_rd = '0; in_rd_wen = 1'b0; in_is_load = 1'b0;
        in_ld_size = 2'b00; in_ld_unsigned = 1'b0; in_addr_lo = 2'b00; in_result = '0;
        mem_rvalid = 1'b0; mem_rdata = '0; mem_rresp = 2'b00;

        // Reset state
        tick(); tick();
        check("rst.wen",    32'(o_wen),      32'd0);
        check("rst.waddr",  32'(o_waddr),    32'd0);
        check("rst.wdata",  o_wdata,         32'd0);
        check("rst.commit", 32'(o_commit),   32'd0);
        check("rst.fault",  32'(o_fault),    32'd0);
        check("rst.ready",  32'(in_ready),   32'd1);
        check("rst.rready", 32'(mem_rready), 32'd0);
        rst_n = 1'b1;
        tick();

        // ALU write to x5
        in_valid = 1'b1; in_rd = 4'd5; in_rd_wen = 1'b1; in_result = 32'h1234_5678;
        tick();
        in_valid = 1'b0;
        check_write("alu", 1'b1, 4'd5, 32'h1234_5678, 1'b0);
`ifdef YSYX_23060124_WB_BYPASS_EN
        check("alu.fwd_valid", 32'(o_fwd_valid), 32'd1);
        check("alu.fwd_data",  o_fwd_data,       32'h1234_5678);
`endif
        tick();
        check("alu.idle_commit", 32'(o_commit), 32'd0);
        check("alu.idle_wen",    32'(o_wen),    32'd0);

        // Signed byte load, 3-cycle latency; a response in the acceptance cycle must be ignored
        issue_load(4'd7, 2'b00, 1'b0, 2'd3);
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
        finish_load("lb", 32'h80AA_BBCC, 2'b00, 2);
        check_write("lb", 1'b1, 4'd7, 32'hFFFF_FF80, 1'b0);
        tick();

        // Unsigned byte load
        issue_load(4'd8, 2'b00, 1'b1, 2'd3);
        finish_load("lbu", 32'h80AA_BBCC, 2'b00, 2);
        check_write("lbu", 1'b1, 4'd8, 32'h0000_0080, 1'b0);
        tick();

        // Signed half load from upper half
        issue_load(4'd9, 2'b01, 1'b0, 2'd2);
        finish_load("lh", 32'h8001_0000, 2'b00, 0);
        check_write("lh", 1'b1, 4'd9, 32'hFFFF_8001, 1'b0);
        tick();

        // Unsigned half load from lower half
        issue_load(4'd10, 2'b01, 1'b1, 2'd0);
        finish_load("lhu", 32'h1234_F00D, 2'b00, 1);
        check_write("lhu", 1'b1, 4'd10, 32'h0000_F00D, 1'b0);
        tick();

        // Misaligned half load faults
        issue_load(4'd9, 2'b01, 1'b0, 2'd1);
        finish_load("lh_mis", 32'h8001_0000, 2'b00, 0);
        check_write("lh_mis", 1'b0, 4'd0, 32'h0, 1'b1);
        tick();

        // Word load
        issue_load(4'd11, 2'b10, 1'b0, 2'd0);
        finish_load("lw", 32'hDEAD_BEEF, 2'b00, 1);
        check_write("lw", 1'b1, 4'd11, 32'hDEAD_BEEF, 1'b0);
        tick();

        // Misaligned word and reserved size fault
        issue_load(4'd11, 2'b10, 1'b0, 2'd2);
        finish_load("lw_mis", 32'hDEAD_BEEF, 2'b00, 0);
        check_write("lw_mis", 1'b0, 4'd0, 32'h0, 1'b1);
        tick();
        issue_load(4'd12, 2'b11, 1'b0, 2'd0);
        finish_load("ld_rsv", 32'hDEAD_BEEF, 2'b00, 0);
        check_write("ld_rsv", 1'b0, 4'd0, 32'h0, 1'b1);
        tick();

        // Bus error response
        issue_load(4'd13, 2'b10, 1'b0, 2'd0);
        finish_load("lw_err", 32'hCAFE_F00D, 2'b10, 2);
        check_write("lw_err", 1'b0, 4'd0, 32'h0, 1'b1);
        tick();

        // x0 write followed by three back-to-back ALU ops
        in_valid = 1'b1; in_is_load = 1'b0; in_rd_wen = 1'b1; in_rd = 4'd0; in_result = 32'h0000_AAAA;
        check("b2b.ready0", 32'(in_ready), 32'd1);
        tick();
        check_write("b2b.x0", 1'b0, 4'd0, 32'h0, 1'b0);
        check("b2b.ready1", 32'(in_ready), 32'd1);
        in_rd = 4'd1; in_result = 32'h0000_0011;
        tick();
        check_write("b2b.x1", 1'b1, 4'd1, 32'h0000_0011, 1'b0);
        check("b2b.ready2", 32'(in_ready), 32'd1);
        in_rd = 4'd2; in_result = 32'h0000_0022;
        tick();
        check_write("b2b.x2", 1'b1, 4'd2, 32'h0000_0022, 1'b0);
        check("b2b.ready3", 32'(in_ready), 32'd1);
        in_rd = 4'd3; in_result = 32'h0000_0033; in_rd_wen = 1'b0;
        tick();
        in_valid = 1'b0;
        check_write("b2b.nowen", 1'b0, 4'd0, 32'h0, 1'b0);
        tick();
        check("b2b.end_commit", 32'(o_commit), 32'd0);

        // Reset while waiting for memory; a late response must be dropped
        issue_load(4'd6, 2'b10, 1'b0, 2'd0);
        tick();
        in_valid = 1'b0; in_is_load = 1'b0;
        check("rstmid.wait_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rstmid.ready",  32'(in_ready),   32'd1);
        check("rstmid.rready", 32'(mem_rready), 32'd0);
        tick();
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
        tick();
        mem_rvalid = 1'b0;
        check("rstmid.wen",    32'(o_wen),    32'd0);
        check("rstmid.commit", 32'(o_commit), 32'd0);
        check("rstmid.fault",  32'(o_fault),  32'd0);
        check("rstmid.wdata",  o_wdata,       32'd0);
        check("rstmid.waddr",  32'(o_waddr),  32'd0);
        check("rstmid.ready2", 32'(in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
